// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcode constants, responder state type and
// the captured-request record used by single-beat memory endpoints.
package tl_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    localparam int NUM_LANES = 8;
    localparam int LANE_W    = 8;
    localparam int DATA_W    = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } resp_state_e;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] size;
        logic [3:0] source;
        logic       denied;
    } a_req_t;

    // Low address bits that must be zero for a transfer of 2^size bytes.
    function automatic logic [2:0] align_mask(input logic [2:0] size);
        case (size)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic is_supported(input logic [2:0] opcode);
        return (opcode == PUT_FULL) || (opcode == PUT_PARTIAL) || (opcode == GET);
    endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port RAM, one byte lane per generate slice, byte write enables and a
// registered read that holds its value until the next read.
module sram_sp
    import tl_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [7:0]        we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [LANE_W-1:0] q;

        always_ff @(posedge clk) begin
            if (en && we[g])
                mem[addr] <= wdata[LANE_W*g +: LANE_W];
            if (en && (we == 8'h00))
                q <= mem[addr];
        end

        assign rdata[LANE_W*g +: LANE_W] = q;
    end

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL single-beat slave: one outstanding Get/PutFull/PutPartial served
// from a local single-port RAM, answered with AccessAck/AccessAckData.
module tl_mem_responder
    import tl_pkg::*;
#(
    parameter int         DEPTH   = 4096,
    parameter int         LATENCY = 1,
    parameter logic [5:0] SINK_ID = 6'd0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [2:0]  a_size,
    input  logic [3:0]  a_source,
    input  logic [63:0] a_address,
    input  logic [7:0]  a_mask,
    input  logic [63:0] a_data,
    input  logic        a_corrupt,
    input  logic        a_valid,
    output logic        a_ready,

    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [2:0]  d_size,
    output logic [3:0]  d_source,
    output logic [5:0]  d_sink,
    output logic        d_denied,
    output logic [63:0] d_data,
    output logic        d_corrupt,
    output logic        d_valid,
    input  logic        d_ready
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    resp_state_e state;
    a_req_t      req;
    a_req_t      req_in;
    logic [3:0]  cnt;

    logic        fire;
    logic        is_get;
    logic        is_put;
    logic        oob;
    logic        misalign;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [63:0] ram_rdata;
    logic        unused_param;

    assign a_ready      = (state == S_IDLE);
    assign d_valid      = (state == S_RESP);
    assign d_param      = 2'd0;
    assign d_sink       = SINK_ID;
    assign fire         = a_valid & a_ready;
    assign unused_param = ^a_param;

    always_comb begin
        is_get   = (a_opcode == GET);
        is_put   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
        oob      = |a_address[63:AW+3];
        misalign = |(a_address[2:0] & align_mask(a_size));

        req_in.opcode = a_opcode;
        req_in.size   = a_size;
        req_in.source = a_source;
        req_in.denied = ~is_supported(a_opcode) | (a_size > 3'd3) | oob | misalign;
    end

    // The RAM is driven straight from the firing beat so its registered read
    // is already settled in the first ACCESS cycle, even when LATENCY is 1.
    assign ram_en = fire & ~req_in.denied & (is_get | ~a_corrupt);
    assign ram_we = is_put ? a_mask : 8'h00;

    sram_sp #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (a_address[3 +: AW]),
        .wdata (a_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req       <= '0;
            cnt       <= '0;
            d_opcode  <= ACCESS_ACK;
            d_size    <= '0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_corrupt <= 1'b0;
            d_data    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        req   <= req_in;
                        cnt   <= CNT_INIT;
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        d_opcode  <= (req.opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
                        d_size    <= req.size;
                        d_source  <= req.source;
                        d_denied  <= req.denied;
                        d_corrupt <= req.denied & (req.opcode == GET);
                        d_data    <= ((req.opcode == GET) && !req.denied) ? ram_rdata : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (d_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
